// File: rtl/lsu_mem_master.sv
// Load/store unit master: one request at a time to a 1024-word synchronous data memory.
// Optional macro LSU_ALIGN_CHECK_EN rejects misaligned or out-of-range addresses with resp_err.
module lsu_mem_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [9:0]  mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        req_ready_r, req_ready_s;
  logic        resp_valid_r, resp_valid_s;
  logic        resp_err_r, resp_err_s;
  logic [31:0] resp_rdata_r, resp_rdata_s;
  logic [9:0]  mem_addr_r, mem_addr_s;
  logic        mem_read_r, mem_read_s;
  logic        mem_write_r, mem_write_s;
  logic [31:0] mem_wdata_r, mem_wdata_s;
  logic        bad_addr_s;

`ifdef LSU_ALIGN_CHECK_EN
  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'd0) || (addr[31:12] != 20'd0);
  endfunction

  assign bad_addr_s = addr_bad(req_addr);
`else
  logic unused_addr_bits_s;

  assign unused_addr_bits_s = ^{req_addr[31:12], req_addr[1:0]};
  assign bad_addr_s         = 1'b0;
`endif

  // Next-state and next-output computation; data registers hold unless updated.
  always_comb begin
    state_s      = state_r;
    req_ready_s  = 1'b0;
    resp_valid_s = 1'b0;
    resp_err_s   = 1'b0;
    resp_rdata_s = resp_rdata_r;
    mem_addr_s   = mem_addr_r;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    mem_wdata_s  = mem_wdata_r;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          if (bad_addr_s) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_err_s   = 1'b1;
          end else begin
            state_s     = ISSUE;
            mem_read_s  = 1'b1;
            mem_write_s = req_we;
            mem_addr_s  = req_addr[11:2];
            mem_wdata_s = req_wdata;
          end
        end else begin
          req_ready_s = 1'b1;
        end
      end
      ISSUE: begin
        // mem_write_r still carries the latched request direction here
        if (mem_write_r) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        state_s      = RESP;
        resp_valid_s = 1'b1;
        resp_rdata_s = mem_rdata;
      end
      RESP: begin
        state_s     = IDLE;
        req_ready_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
      mem_addr_r   <= 10'd0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_wdata_r  <= 32'd0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_err_r   <= resp_err_s;
      resp_rdata_r <= resp_rdata_s;
      mem_addr_r   <= mem_addr_s;
      mem_read_r   <= mem_read_s;
      mem_write_r  <= mem_write_s;
      mem_wdata_r  <= mem_wdata_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign mem_addr   = mem_addr_r;
  assign mem_read   = mem_read_r;
  assign mem_write  = mem_write_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: transaction-level timing model plus directed literal pins and random traffic.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  // Model state: one outstanding transaction, described by the cycles its events land on.
  int          cyc = 0;
  int          free_at = 0;
  int          strobe_at = -1;
  int          resp_at = -1;
  logic        strobe_we = 1'b0;
  logic        resp_err_p = 1'b0;
  logic        resp_load = 1'b0;
  logic [31:0] resp_data_p = 32'd0;
  logic [31:0] e_rdata = 32'd0;
  logic [31:0] e_wdata = 32'd0;
  logic [9:0]  e_addr = 10'd0;

  lsu_mem_master dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous data memory: write on enable+we, otherwise registered read.
  always @(posedge clk) begin
    if (mem_read) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      else           mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: compare DUT with model, then drive this cycle's inputs and update the model.
  task automatic tick(input logic r, input logic v, input logic we,
                      input logic [31:0] a, input logic [31:0] d);
    logic       e_ready, e_read, e_write, e_valid, e_err, bad;
    logic [9:0] word;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      e_rdata   = 32'd0;
      e_addr    = 10'd0;
      e_wdata   = 32'd0;
      strobe_at = -1;
      resp_at   = -1;
      free_at   = cyc + 1;
    end
    e_ready = (cyc >= free_at);
    e_read  = (cyc == strobe_at);
    e_write = e_read && strobe_we;
    e_valid = (cyc == resp_at);
    e_err   = e_valid && resp_err_p;
    if (e_valid && resp_load) e_rdata = resp_data_p;
    chk("req_ready",  {31'd0, req_ready},  {31'd0, e_ready});
    chk("mem_read",   {31'd0, mem_read},   {31'd0, e_read});
    chk("mem_write",  {31'd0, mem_write},  {31'd0, e_write});
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, e_valid});
    chk("resp_err",   {31'd0, resp_err},   {31'd0, e_err});
    chk("resp_rdata", resp_rdata, e_rdata);
    chk("mem_addr",   {22'd0, mem_addr}, {22'd0, e_addr});
    chk("mem_wdata",  mem_wdata, e_wdata);

    rst       = r;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    if (!r && v && e_ready) begin
      word = a[11:2];
`ifdef LSU_ALIGN_CHECK_EN
      bad = (a[1:0] != 2'd0) || (a[31:12] != 20'd0);
`else
      bad = 1'b0;
`endif
      if (bad) begin
        resp_at    = cyc + 1;
        resp_err_p = 1'b1;
        resp_load  = 1'b0;
        free_at    = cyc + 2;
      end else begin
        e_addr     = word;
        e_wdata    = d;
        strobe_at  = cyc + 1;
        strobe_we  = we;
        resp_err_p = 1'b0;
        if (we) begin
          ref_mem[word] = d;
          resp_load     = 1'b0;
          resp_at       = cyc + 2;
          free_at       = cyc + 3;
        end else begin
          resp_load   = 1'b1;
          resp_data_p = ref_mem[word];
          resp_at     = cyc + 3;
          free_at     = cyc + 4;
        end
      end
    end
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] w, a;
    for (int i = 0; i < 1024; i++) begin
      w          = $urandom;
      mem[i]     = w;
      ref_mem[i] = w;
    end

    tick(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("pin_ready_in_reset", {31'd0, req_ready}, 32'd0);
    chk("pin_rdata_reset", resp_rdata, 32'd0);

    tick(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("pin_ready_after_reset", {31'd0, req_ready}, 32'd1);
    idle();
    chk("pin_st_addr", {22'd0, mem_addr}, 32'd4);
    chk("pin_st_read", {31'd0, mem_read}, 32'd1);
    chk("pin_st_write", {31'd0, mem_write}, 32'd1);
    chk("pin_st_wdata", mem_wdata, 32'hDEAD_BEEF);
    idle();
    chk("pin_st_resp", {31'd0, resp_valid}, 32'd1);

    tick(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
    idle();
    chk("pin_ld_read", {31'd0, mem_read}, 32'd1);
    chk("pin_ld_write", {31'd0, mem_write}, 32'd0);
    idle();
    idle();
    chk("pin_ld_resp", {31'd0, resp_valid}, 32'd1);
    chk("pin_ld_rdata", resp_rdata, 32'hDEAD_BEEF);

    tick(1'b0, 1'b1, 1'b1, 32'h0000_0FFC, 32'h1234_5678);
    idle();
    chk("pin_top_st_addr", {22'd0, mem_addr}, 32'h0000_03FF);
    idle();
    tick(1'b0, 1'b1, 1'b0, 32'h0000_0FFC, 32'd0);
    idle();
    chk("pin_top_ld_addr", {22'd0, mem_addr}, 32'h0000_03FF);
    idle();
    idle();
    chk("pin_top_ld_rdata", resp_rdata, 32'h1234_5678);

    tick(1'b0, 1'b1, 1'b0, 32'h0000_0012, 32'd0);
    idle();
`ifdef LSU_ALIGN_CHECK_EN
    chk("pin_mis_valid", {31'd0, resp_valid}, 32'd1);
    chk("pin_mis_err", {31'd0, resp_err}, 32'd1);
    chk("pin_mis_read", {31'd0, mem_read}, 32'd0);
    chk("pin_mis_rdata", resp_rdata, 32'h1234_5678);
`else
    chk("pin_mis_read", {31'd0, mem_read}, 32'd1);
    chk("pin_mis_addr", {22'd0, mem_addr}, 32'd4);
`endif
    idle();
    idle();
`ifndef LSU_ALIGN_CHECK_EN
    chk("pin_mis_rdata", resp_rdata, 32'hDEAD_BEEF);
`endif

    tick(1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
    idle();
    tick(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("pin_abort_valid", {31'd0, resp_valid}, 32'd0);
    chk("pin_abort_rdata", resp_rdata, 32'd0);
    idle();
    chk("pin_abort_ready", {31'd0, req_ready}, 32'd1);
    chk("pin_abort_novalid", {31'd0, resp_valid}, 32'd0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), a, $urandom);
    end
    idle();
    idle();
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have a single clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Port list: `clk`  in  1  clock, all state rising-edge.
REQ-003 Port list: `rst`  in  1  synchronous active-high reset.
REQ-004 Port list: `req_valid`  in  1  load/store request present.
REQ-005 Port list: `req_ready`  out  1  block can accept a request.
REQ-006 Port list: `req_we`  in  1  1=store, 0=load.
REQ-007 Port list: `req_addr`  in  32  byte address.
REQ-008 Port list: `req_wdata`  in  32  store data.
REQ-009 Port list: `resp_valid`  out  1  one-cycle completion pulse.
REQ-010 Port list: `resp_rdata`  out  32  load data.
REQ-011 Port list: `resp_err`  out  1  request rejected (see REQ-030).
REQ-012 Port list: `mem_addr`  out  10  word address to data memory.
REQ-013 Port list: `mem_read`  out  1  memory enable (ena).
REQ-014 Port list: `mem_write`  out  1  memory write enable (wea).
REQ-015 Port list: `mem_wdata`  out  32  memory write data.
REQ-016 Port list: `mem_rdata`  in  32  memory read data, valid one cycle after enable.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT, RESP; all outputs SHALL be registered.
REQ-018 `req_ready` SHALL be 1 only in IDLE; handshake occurs in cycle T when `req_valid`=1 and `req_ready`=1.
REQ-019 On handshake the block SHALL latch `req_we`, `req_wdata` and `mem_addr`=`req_addr[11:2]`; IDLE->ISSUE.
REQ-020 In ISSUE (cycle T+1), `mem_read` SHALL be 1 for exactly one cycle; `mem_write` SHALL equal the latched `req_we`; `mem_wdata` SHALL equal the latched data.
REQ-021 The memory writes only while its enable is high, so `mem_read` SHALL also be 1 during a store issue.
REQ-022 Store: ISSUE->RESP; `resp_valid`=1 in T+2.
REQ-023 Load: ISSUE->WAIT; `mem_rdata` SHALL be captured into `resp_rdata` at the end of T+2; WAIT->RESP; `resp_valid`=1 in T+3.
REQ-024 RESP SHALL last one cycle, then go to IDLE; the next handshake can occur no earlier than the following cycle.
REQ-025 `resp_rdata` SHALL hold the last load value and SHALL NOT change on stores or errors.
REQ-026 `mem_read` and `mem_write` SHALL be 0 outside ISSUE; `mem_addr` and `mem_wdata` SHALL hold their last value.
REQ-027 `req_valid` outside IDLE SHALL be ignored; there is no queuing.

Reset
REQ-028 While `rst`=1 at a rising edge: state=IDLE; `resp_valid`, `resp_err`, `mem_read`, `mem_write`=0; `resp_rdata`, `mem_addr`, `mem_wdata`=0; `req_ready`=0 during the reset cycle, 1 after.
REQ-029 Reset mid-operation SHALL abandon the access with no `resp_valid`; a strobe in flight SHALL be cleared at the reset edge.

Configuration
REQ-030 With `LSU_ALIGN_CHECK_EN` defined: a request with `req_addr[1:0]`!=0 or `req_addr[31:12]`!=0 SHALL be accepted and SHALL go IDLE->RESP with no memory strobe; `resp_valid`=1 and `resp_err`=1 in T+1. `resp_err`=0 on all other responses.
REQ-031 Without `LSU_ALIGN_CHECK_EN`: `req_addr[1:0]` and `req_addr[31:12]` SHALL be ignored and `resp_err` SHALL be constant 0.

Verification
REQ-032 Store addr 0x0000_0010, data 0xDEADBEEF at T -> T+1: mem_addr=4, mem_read=1, mem_write=1; T+2: resp_valid=1.
REQ-033 Load 0x0000_0010 after REQ-032, with a memory model -> T+1: mem_read=1, mem_write=0; T+3: resp_valid=1, resp_rdata=0xDEADBEEF.
REQ-034 Back-to-back req_valid held high -> handshakes no closer than 4 cycles for loads, 3 for stores; exactly one strobe per request.
REQ-035 rst asserted in the WAIT cycle of a load -> no resp_valid; req_ready=1 in the cycle after reset is released; resp_rdata=0.
REQ-036 With LSU_ALIGN_CHECK_EN, load 0x0000_0012 -> T+1: resp_valid=1, resp_err=1, mem_read=0, resp_rdata unchanged. Without it -> normal load of word 4.
REQ-037 Load 0x0000_0FFC -> mem_addr=0x3FF; data returned correctly at the top word.
